multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Control FSM that sequences the shared datapath of the multi-cycle version of the CPU: one ALU, one unified instruction/data memory port, register file, IR/MDR/ALUOut/A/B latches. It decodes the custom opcode set (R-type, addi, lw, sw, beq, bne, blt, bnez, bgez, j, jal, jr) and drives per-cycle mux selects and write strobes. It also keeps retired-instruction and cycle counters for the bench.

## Interface
- No parameters; opcode, funct and ALU encodings are fixed below.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_i  in  6  IR[31:26]
- funct_i  in  6  IR[5:0]
- zero_i  in  1  ALU result == 0
- neg_i  in  1  signed ALU A < ALU B (true overflow-corrected less-than)
- pc_we_o  out  1  PC write enable
- pc_src_o  out  2  PC source: 0 ALU result, 1 ALUOut, 2 {PC[31:28],IR[25:0],2'b00}, 3 A (rs)
- iord_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_re_o / mem_we_o  out  1 each  memory read / write strobe
- ir_we_o  out  1  IR load
- reg_we_o  out  1  register file write
- reg_dst_o  out  2  0 rt, 1 rd, 2 r31
- mem_to_reg_o  out  2  0 ALUOut, 1 MDR, 2 PC
- alu_src_a_o  out  2  0 PC, 1 A (rs), 2 IR[10:6] zero-extended
- alu_src_b_o  out  3  0 B (rt), 1 const 4, 2 sext imm, 3 sext imm<<2, 4 const 0
- alu_ctrl_o  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, NOR 1100
- state_o  out  4  current state encoding
- instr_done_o  out  1  high in the final cycle of each instruction
- illegal_o  out  1  sticky; set on undefined op/funct
- instr_cnt_o / cycle_cnt_o  out  32 each  retired instructions / cycles since reset

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BRANCH 11, JUMP 12, JAL 13, JR 14, HALT 15.
- All outputs are 0 unless listed for the state below.
- IDLE: all strobes 0. Goes to FETCH.
- FETCH: iord 0, mem_re, ir_we, A=PC, B=4, ADD, pc_we, pc_src 0. Goes to DECODE.
- DECODE: A=PC, B=imm<<2, ADD, so ALUOut holds the branch target.
  - op 000000: jr (funct 000001) goes to JR; any other valid funct goes to R_EXEC.
  - 010011 addi goes to I_EXEC. 011000 lw and 101000 sw go to MEM_ADDR.
  - 011001/011010/011100/011101/011110 go to BRANCH.
  - 001100 goes to JUMP. 001111 goes to JAL.
  - Anything else goes to HALT.
- R_EXEC: B=rt.
  - A=rs for add 100011, sub 010011, and 011111, or 101111, nor 010000, slt 010100, sllv 011000, srlv 101000.
  - A=shamt for sll 010010 and srl 100010.
  - alu_ctrl follows from funct. Then R_WB.
- R_WB: reg_we, reg_dst 1, mem_to_reg 0.
- I_EXEC: A=rs, B=sext imm, ADD. I_WB: reg_we, reg_dst 0, mem_to_reg 0.
- MEM_ADDR: A=rs, B=sext imm, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord 1, mem_re. MEM_WB: reg_we, reg_dst 0, mem_to_reg 1.
- MEM_WR: iord 1, mem_we.
- BRANCH: A=rs, SUB. B=rt for beq/bne/blt; B=const 0 for bnez/bgez. pc_src 1. pc_we is combinational (Mealy):
  - beq: zero_i
  - bne: !zero_i
  - blt: neg_i
  - bnez: !zero_i
  - bgez: !neg_i
- JUMP: pc_we, pc_src 2.
- JAL: pc_we, pc_src 2, reg_we, reg_dst 2, mem_to_reg 2. The write uses the old PC, which already holds PC+4.
- JR: pc_we, pc_src 3.
- Terminal states R_WB, I_WB, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR: assert instr_done_o and return to FETCH.
- HALT: illegal_o set; all strobes 0; stays in HALT until reset. An all-zero word (funct 000000) is illegal.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, all outputs 0, counters 0, illegal_o 0. The first FETCH is the cycle after rst_n rises.
- Cycles per instruction (FETCH to done, inclusive):
  - 3: branches, j, jal, jr
  - 4: R-type, addi, sw
  - 5: lw
- cycle_cnt_o increments every clock outside reset, including IDLE and HALT. Both counters wrap at 2^32.
- instr_cnt_o increments on the edge that ends a cycle with instr_done_o=1. It is visible in the next cycle.
- Reset asserted mid-instruction aborts it. No strobe may be asserted while rst_n=0.
- Memory read data is used one cycle after mem_re. The IR and MDR latch on the edge ending the mem_re cycle.

## Test plan
- Reset release then `addi r1,r0,5`: states 0→1→2→9→10→1. reg_we only in I_WB with reg_dst 0. instr_cnt_o=1 afterwards.
- R-type sweep: add/sub/and/or/nor/slt/sllv/sll/srlv/srl/jr each give the listed alu_ctrl_o and alu_src_a_o (2 only for sll/srl). jr gives pc_src 3 in state 14.
- Branches with zero_i/neg_i forced to each of the 4 combinations:
  - beq: pc_we = zero_i
  - bne: pc_we = !zero_i
  - blt: pc_we = neg_i
  - bnez: pc_we = !zero_i
  - bgez: pc_we = !neg_i
  - For bnez/bgez, alu_src_b_o=4.
- lw then sw: lw takes 5 cycles with iord 1 and mem_re in state 4, then reg_we with mem_to_reg 1. sw takes 4 cycles with mem_we only in state 6.
- jal: in state 13, pc_src 2, reg_dst 2, mem_to_reg 2, reg_we and pc_we together, instr_done_o 1.
- Illegal op 111111, and separately a zero word: HALT (15), illegal_o=1, no strobes for 10 cycles. rst_n pulse mid-lw (state 4) forces IDLE immediately and clears counters.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle CPU: sequences the shared ALU, memory port and latches,
// and keeps retired-instruction and cycle counters.
module multi_cycle_ctrl (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic [5:0]  op_i,
   input  logic [5:0]  funct_i,
   input  logic        zero_i,
   input  logic        neg_i,
   output logic        pc_we_o,
   output logic [1:0]  pc_src_o,
   output logic        iord_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   output logic        ir_we_o,
   output logic        reg_we_o,
   output logic [1:0]  reg_dst_o,
   output logic [1:0]  mem_to_reg_o,
   output logic [1:0]  alu_src_a_o,
   output logic [2:0]  alu_src_b_o,
   output logic [3:0]  alu_ctrl_o,
   output logic [3:0]  state_o,
   output logic        instr_done_o,
   output logic        illegal_o,
   output logic [31:0] instr_cnt_o,
   output logic [31:0] cycle_cnt_o
);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,  StFetch  = 4'd1,  StDecode = 4'd2,  StMemAddr = 4'd3,
      StMemRd   = 4'd4,  StMemWb  = 4'd5,  StMemWr  = 4'd6,  StRExec   = 4'd7,
      StRWb     = 4'd8,  StIExec  = 4'd9,  StIWb    = 4'd10, StBranch  = 4'd11,
      StJump    = 4'd12, StJal    = 4'd13, StJr     = 4'd14, StHalt    = 4'd15
   } state_e;

   localparam logic [5:0] OpR = 6'b000000, OpAddi = 6'b010011, OpLw = 6'b011000;
   localparam logic [5:0] OpSw = 6'b101000, OpBeq = 6'b011001, OpBne = 6'b011010;
   localparam logic [5:0] OpBlt = 6'b011100, OpBnez = 6'b011101, OpBgez = 6'b011110;
   localparam logic [5:0] OpJ = 6'b001100, OpJal = 6'b001111, FnJr = 6'b000001;

   localparam logic [3:0] AluAnd = 4'b0000, AluOr = 4'b0001, AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110, AluSlt = 4'b0111, AluSll = 4'b1000;
   localparam logic [3:0] AluSrl = 4'b1001, AluNor = 4'b1100;

   state_e      state_q, state_d;
   logic        illegal_q, illegal_d;
   logic [31:0] instr_cnt_q, instr_cnt_d, cycle_cnt_q, cycle_cnt_d;

   logic        r_valid, r_shamt;
   logic [3:0]  r_alu;

   // R-type funct decode; r_shamt selects IR[10:6] as the ALU A operand
   always_comb begin
      r_valid = 1'b1;
      r_shamt = 1'b0;
      r_alu   = AluAdd;
      case (funct_i)
         6'b100011: r_alu = AluAdd;
         6'b010011: r_alu = AluSub;
         6'b011111: r_alu = AluAnd;
         6'b101111: r_alu = AluOr;
         6'b010000: r_alu = AluNor;
         6'b010100: r_alu = AluSlt;
         6'b011000: r_alu = AluSll;
         6'b101000: r_alu = AluSrl;
         6'b010010: begin r_alu = AluSll; r_shamt = 1'b1; end
         6'b100010: begin r_alu = AluSrl; r_shamt = 1'b1; end
         default:   r_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_we_o      = 1'b0;
      pc_src_o     = 2'd0;
      iord_o       = 1'b0;
      mem_re_o     = 1'b0;
      mem_we_o     = 1'b0;
      ir_we_o      = 1'b0;
      reg_we_o     = 1'b0;
      reg_dst_o    = 2'd0;
      mem_to_reg_o = 2'd0;
      alu_src_a_o  = 2'd0;
      alu_src_b_o  = 3'd0;
      alu_ctrl_o   = 4'd0;
      instr_done_o = 1'b0;
      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            mem_re_o    = 1'b1;
            ir_we_o     = 1'b1;
            alu_src_b_o = 3'd1;
            alu_ctrl_o  = AluAdd;
            pc_we_o     = 1'b1;
            state_d     = StDecode;
         end
         StDecode: begin
            alu_src_b_o = 3'd3;
            alu_ctrl_o  = AluAdd;
            case (op_i)
               OpR:                               state_d = (funct_i == FnJr) ? StJr :
                                                            r_valid ? StRExec : StHalt;
               OpAddi:                            state_d = StIExec;
               OpLw, OpSw:                        state_d = StMemAddr;
               OpBeq, OpBne, OpBlt, OpBnez, OpBgez: state_d = StBranch;
               OpJ:                               state_d = StJump;
               OpJal:                             state_d = StJal;
               default:                           state_d = StHalt;
            endcase
         end
         StRExec: begin
            alu_src_a_o = r_shamt ? 2'd2 : 2'd1;
            alu_ctrl_o  = r_alu;
            state_d     = StRWb;
         end
         StRWb: begin
            reg_we_o = 1'b1; reg_dst_o = 2'd1; instr_done_o = 1'b1; state_d = StFetch;
         end
         StIExec, StMemAddr: begin
            alu_src_a_o = 2'd1;
            alu_src_b_o = 3'd2;
            alu_ctrl_o  = AluAdd;
            if (state_q == StIExec) state_d = StIWb;
            else                    state_d = (op_i == OpLw) ? StMemRd : StMemWr;
         end
         StIWb: begin
            reg_we_o = 1'b1; instr_done_o = 1'b1; state_d = StFetch;
         end
         StMemRd: begin
            iord_o = 1'b1; mem_re_o = 1'b1; state_d = StMemWb;
         end
         StMemWb: begin
            reg_we_o = 1'b1; mem_to_reg_o = 2'd1; instr_done_o = 1'b1; state_d = StFetch;
         end
         StMemWr: begin
            iord_o = 1'b1; mem_we_o = 1'b1; instr_done_o = 1'b1; state_d = StFetch;
         end
         StBranch: begin
            alu_src_a_o  = 2'd1;
            alu_src_b_o  = (op_i == OpBnez || op_i == OpBgez) ? 3'd4 : 3'd0;
            alu_ctrl_o   = AluSub;
            pc_src_o     = 2'd1;
            instr_done_o = 1'b1;
            state_d      = StFetch;
            case (op_i)
               OpBeq:   pc_we_o = zero_i;
               OpBne:   pc_we_o = !zero_i;
               OpBlt:   pc_we_o = neg_i;
               OpBnez:  pc_we_o = !zero_i;
               OpBgez:  pc_we_o = !neg_i;
               default: pc_we_o = 1'b0;
            endcase
         end
         StJump: begin
            pc_we_o = 1'b1; pc_src_o = 2'd2; instr_done_o = 1'b1; state_d = StFetch;
         end
         // PC already holds PC+4, so mem_to_reg 2 writes the return address
         StJal: begin
            pc_we_o      = 1'b1;
            pc_src_o     = 2'd2;
            reg_we_o     = 1'b1;
            reg_dst_o    = 2'd2;
            mem_to_reg_o = 2'd2;
            instr_done_o = 1'b1;
            state_d      = StFetch;
         end
         StJr: begin
            pc_we_o = 1'b1; pc_src_o = 2'd3; instr_done_o = 1'b1; state_d = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   assign illegal_d   = illegal_q | (state_d == StHalt);
   assign cycle_cnt_d = cycle_cnt_q + 32'd1;
   assign instr_cnt_d = instr_cnt_q + {31'd0, instr_done_o};

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         illegal_q   <= 1'b0;
         instr_cnt_q <= 32'd0;
         cycle_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         illegal_q   <= illegal_d;
         instr_cnt_q <= instr_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign state_o     = state_q;
   assign illegal_o   = illegal_q;
   assign instr_cnt_o = instr_cnt_q;
   assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle traces for multi-cycle corner cases plus a
// table of instructions whose expected results flow through a scoreboard queue.
module tb_multi_cycle_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b1;
   logic [5:0]  op_i = 6'd0, funct_i = 6'd0;
   logic        zero_i = 1'b0, neg_i = 1'b0;
   logic        pc_we_o, iord_o, mem_re_o, mem_we_o, ir_we_o, reg_we_o;
   logic [1:0]  pc_src_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
   logic [2:0]  alu_src_b_o;
   logic [3:0]  alu_ctrl_o, state_o;
   logic        instr_done_o, illegal_o;
   logic [31:0] instr_cnt_o, cycle_cnt_o;

   multi_cycle_ctrl dut (
      .clk_i(clk_i), .rst_n(rst_n), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
      .neg_i(neg_i), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .iord_o(iord_o),
      .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .ir_we_o(ir_we_o), .reg_we_o(reg_we_o),
      .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
      .alu_src_b_o(alu_src_b_o), .alu_ctrl_o(alu_ctrl_o), .state_o(state_o),
      .instr_done_o(instr_done_o), .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o),
      .cycle_cnt_o(cycle_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // {pc_we, mem_re, mem_we, ir_we, reg_we, iord, done, reg_dst, mem_to_reg}
   logic [10:0] sv;
   assign sv = {pc_we_o, mem_re_o, mem_we_o, ir_we_o, reg_we_o, iord_o, instr_done_o,
                reg_dst_o, mem_to_reg_o};

   localparam logic [10:0] SvFetch = 11'b1101000_00_00;
   localparam logic [10:0] SvNone  = 11'b0000000_00_00;
   localparam logic [10:0] SvIWb   = 11'b0000101_00_00;
   localparam logic [10:0] SvMemRd = 11'b0100010_00_00;
   localparam logic [10:0] SvMemWb = 11'b0000101_00_01;
   localparam logic [10:0] SvMemWr = 11'b0010011_00_00;
   localparam logic [10:0] SvJal   = 11'b1000101_10_10;

   typedef struct {
      string      nm;
      logic [5:0] op, fn;
      logic       z, n;
      int         cyc;
      logic [3:0] fin, alu;
      logic [1:0] srca;
      logic [2:0] srcb;
      logic       pcwe;
      logic [1:0] pcsrc;
   } vec_t;

   vec_t        vt[$];
   vec_t        sb[$];
   logic [14:0] ex[6];
   int          n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic n, input int cyc,
                               input logic [3:0] fin, input logic [3:0] alu,
                               input logic [1:0] srca, input logic [2:0] srcb,
                               input logic pcwe, input logic [1:0] pcsrc);
      vec_t v;
      v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.n = n; v.cyc = cyc; v.fin = fin;
      v.alu = alu; v.srca = srca; v.srcb = srcb; v.pcwe = pcwe; v.pcsrc = pcsrc;
      return v;
   endfunction

   // Starts on the negedge of a FETCH cycle, ends on the next FETCH negedge
   task automatic trace(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input int len);
      op_i = op; funct_i = fn; zero_i = 1'b0; neg_i = 1'b0;
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s c%0d state", nm, i), {28'd0, state_o}, {28'd0, ex[i][14:11]});
         chk($sformatf("%s c%0d strobes", nm, i), {21'd0, sv}, {21'd0, ex[i][10:0]});
         @(negedge clk_i);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int         cyc = 0;
      logic [3:0] fin = 4'd0, alu = 4'd0;
      logic [1:0] srca = 2'd0, pcsrc = 2'd0;
      logic [2:0] srcb = 3'd0;
      logic       pcwe = 1'b0;
      vec_t       e;
      op_i = v.op; funct_i = v.fn; zero_i = v.z; neg_i = v.n;
      sb.push_back(v);
      chk({v.nm, " start"}, {28'd0, state_o}, 32'd1);
      for (int c = 1; c <= 10; c++) begin
         if (c == 3) begin
            alu = alu_ctrl_o; srca = alu_src_a_o; srcb = alu_src_b_o;
         end
         if (instr_done_o) begin
            cyc = c; fin = state_o; pcwe = pc_we_o; pcsrc = pc_src_o;
            break;
         end
         @(negedge clk_i);
      end
      @(negedge clk_i);
      e = sb.pop_front();
      chk({e.nm, " cycles"}, cyc, e.cyc);
      chk({e.nm, " final state"}, {28'd0, fin}, {28'd0, e.fin});
      chk({e.nm, " alu_ctrl"}, {28'd0, alu}, {28'd0, e.alu});
      chk({e.nm, " src_a"}, {30'd0, srca}, {30'd0, e.srca});
      chk({e.nm, " src_b"}, {29'd0, srcb}, {29'd0, e.srcb});
      chk({e.nm, " pc_we"}, {31'd0, pcwe}, {31'd0, e.pcwe});
      chk({e.nm, " pc_src"}, {30'd0, pcsrc}, {30'd0, e.pcsrc});
   endtask

   task automatic check_reset(input string nm);
      chk({nm, " state"}, {28'd0, state_o}, 32'd0);
      chk({nm, " strobes"}, {21'd0, sv}, 32'd0);
      chk({nm, " illegal"}, {31'd0, illegal_o}, 32'd0);
      chk({nm, " instr_cnt"}, instr_cnt_o, 32'd0);
      chk({nm, " cycle_cnt"}, cycle_cnt_o, 32'd0);
   endtask

   // Called on a negedge; leaves the bench on the negedge of the first FETCH
   task automatic do_reset(input string nm);
      rst_n = 1'b0;
      #1;
      check_reset(nm);
      @(negedge clk_i);
      rst_n = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic halt_seq(input string nm, input logic [5:0] op, input logic [5:0] fn);
      ex[0] = {4'd1, SvFetch}; ex[1] = {4'd2, SvNone};
      trace(nm, op, fn, 2);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("%s h%0d state", nm, i), {28'd0, state_o}, 32'd15);
         chk($sformatf("%s h%0d illegal", nm, i), {31'd0, illegal_o}, 32'd1);
         chk($sformatf("%s h%0d strobes", nm, i), {21'd0, sv}, 32'd0);
         @(negedge clk_i);
      end
   endtask

   initial begin
      logic [5:0] bops[5];
      logic       take;
      bops[0] = 6'b011001; bops[1] = 6'b011010; bops[2] = 6'b011100;
      bops[3] = 6'b011101; bops[4] = 6'b011110;

      vt.push_back(mk("add",  6'd0, 6'b100011, 0, 0, 4, 4'd8, 4'b0010, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("sub",  6'd0, 6'b010011, 0, 0, 4, 4'd8, 4'b0110, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("and",  6'd0, 6'b011111, 0, 0, 4, 4'd8, 4'b0000, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("or",   6'd0, 6'b101111, 0, 0, 4, 4'd8, 4'b0001, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("nor",  6'd0, 6'b010000, 0, 0, 4, 4'd8, 4'b1100, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("slt",  6'd0, 6'b010100, 0, 0, 4, 4'd8, 4'b0111, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("sllv", 6'd0, 6'b011000, 0, 0, 4, 4'd8, 4'b1000, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("sll",  6'd0, 6'b010010, 0, 0, 4, 4'd8, 4'b1000, 2'd2, 3'd0, 0, 2'd0));
      vt.push_back(mk("srlv", 6'd0, 6'b101000, 0, 0, 4, 4'd8, 4'b1001, 2'd1, 3'd0, 0, 2'd0));
      vt.push_back(mk("srl",  6'd0, 6'b100010, 0, 0, 4, 4'd8, 4'b1001, 2'd2, 3'd0, 0, 2'd0));
      vt.push_back(mk("jr",   6'd0, 6'b000001, 0, 0, 3, 4'd14, 4'b0000, 2'd0, 3'd0, 1, 2'd3));
      vt.push_back(mk("addi", 6'b010011, 6'd5, 0, 0, 4, 4'd10, 4'b0010, 2'd1, 3'd2, 0, 2'd0));
      vt.push_back(mk("lw",   6'b011000, 6'd0, 0, 0, 5, 4'd5, 4'b0010, 2'd1, 3'd2, 0, 2'd0));
      vt.push_back(mk("sw",   6'b101000, 6'd0, 0, 0, 4, 4'd6, 4'b0010, 2'd1, 3'd2, 0, 2'd0));
      vt.push_back(mk("j",    6'b001100, 6'd0, 0, 0, 3, 4'd12, 4'b0000, 2'd0, 3'd0, 1, 2'd2));
      vt.push_back(mk("jal",  6'b001111, 6'd0, 0, 0, 3, 4'd13, 4'b0000, 2'd0, 3'd0, 1, 2'd2));
      for (int k = 0; k < 5; k++) begin
         for (int zn = 0; zn < 4; zn++) begin
            logic z, n;
            z = zn[1]; n = zn[0];
            case (k)
               0:       take = z;
               1:       take = !z;
               2:       take = n;
               3:       take = !z;
               default: take = !n;
            endcase
            vt.push_back(mk($sformatf("br%0d z%0d n%0d", k, z, n), bops[k], 6'd0, z, n, 3,
                            4'd11, 4'b0110, 2'd1, (k >= 3) ? 3'd4 : 3'd0, take, 2'd1));
         end
      end

      #2 rst_n = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      check_reset("reset");
      rst_n = 1'b1;
      chk("idle after release", {28'd0, state_o}, 32'd0);
      @(negedge clk_i);

      ex[0] = {4'd1, SvFetch}; ex[1] = {4'd2, SvNone}; ex[2] = {4'd9, SvNone};
      ex[3] = {4'd10, SvIWb};
      trace("addi", 6'b010011, 6'd5, 4);
      chk("instr_cnt after addi", instr_cnt_o, 32'd1);
      chk("cycle_cnt after addi", cycle_cnt_o, 32'd5);

      ex[2] = {4'd3, SvNone}; ex[3] = {4'd4, SvMemRd}; ex[4] = {4'd5, SvMemWb};
      trace("lw", 6'b011000, 6'd0, 5);
      ex[3] = {4'd6, SvMemWr};
      trace("sw", 6'b101000, 6'd0, 4);
      ex[2] = {4'd13, SvJal};
      trace("jal", 6'b001111, 6'd0, 3);
      chk("instr_cnt after jal", instr_cnt_o, 32'd4);

      foreach (vt[i]) run_vec(vt[i]);
      chk("instr_cnt after table", instr_cnt_o, 32'd4 + vt.size());
      chk("scoreboard drained", sb.size(), 32'd0);

      halt_seq("op111111", 6'b111111, 6'd0);
      do_reset("reset after halt");
      halt_seq("zero word", 6'd0, 6'd0);
      do_reset("reset after zero word");

      op_i = 6'b011000; funct_i = 6'd0;
      repeat (3) @(negedge clk_i);
      chk("mid-lw state", {28'd0, state_o}, 32'd4);
      chk("mid-lw mem_re", {31'd0, mem_re_o}, 32'd1);
      do_reset("mid-lw reset");
      chk("fetch after mid-lw reset", {28'd0, state_o}, 32'd1);
      chk("cycle_cnt after mid-lw reset", cycle_cnt_o, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
